// File: rtl/lcd_char_controller.sv
// lcd_char_controller: drives an HD44780-style character LCD over its 4-bit bus.
// Runs the power-up init sequence, then accepts one command strobe at a time
// (clear > home > set_pos > write_char) and tracks the cursor position.
//
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_char, i_write_char            character code and write strobe
//   i_home, i_clear, i_set_pos      command strobes
//   i_pos_line, i_pos_col           set_pos target (clamped to LINES-1 / COLS-1)
//   o_db, o_rs, o_enable            LCD DB7..DB4 (o_db[0] = DB4), RS, E
//   o_ready                         idle, one strobe will be accepted
//   o_cursor_line, o_cursor_col     tracked cursor position
//
// Optional feature: define LCD_AUTO_WRAP_EN to wrap to the next line (and send
// the matching DDRAM address) when a write fills the last column.
module lcd_char_controller #(
  parameter int unsigned CLK_MHZ  = 50,
  parameter int unsigned POWER_MS = 130,
  parameter int unsigned WAKE_MS  = 10,
  parameter int unsigned EN_US    = 1,
  parameter int unsigned EXEC_US  = 50,
  parameter int unsigned CLEAR_MS = 2,
  parameter int unsigned LINES    = 2,
  parameter int unsigned COLS     = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_char,
  input  logic       i_write_char,
  input  logic       i_home,
  input  logic       i_clear,
  input  logic       i_set_pos,
  input  logic [1:0] i_pos_line,
  input  logic [5:0] i_pos_col,
  output logic [3:0] o_db,
  output logic       o_rs,
  output logic       o_enable,
  output logic       o_ready,
  output logic [1:0] o_cursor_line,
  output logic [5:0] o_cursor_col
);

  localparam int unsigned PowerCyc = CLK_MHZ * POWER_MS * 1000;
  localparam int unsigned WakeCyc  = CLK_MHZ * WAKE_MS * 1000;
  localparam int unsigned EnCyc    = CLK_MHZ * EN_US;
  localparam int unsigned ExecCyc  = CLK_MHZ * EXEC_US;
  localparam int unsigned ClearCyc = CLK_MHZ * CLEAR_MS * 1000;

  localparam logic [1:0] LastLine = 2'(LINES - 1);
  localparam logic [5:0] LastCol  = 6'(COLS - 1);
  localparam logic [5:0] ColsW    = 6'(COLS);
  localparam logic [6:0] Base2    = 7'(COLS);
  localparam logic [6:0] Base3    = 7'(64 + COLS);
  localparam logic [7:0] FuncSet  = (LINES == 1) ? 8'h20 : 8'h28;

  typedef enum logic [2:0] {
    StPowerWait, StInitStep, StLoad, StSetup, StEnHi, StEnLo, StWait, StReady
  } state_e;

  typedef enum logic [1:0] {OpChar, OpClear, OpHome, OpPos} op_e;

  state_e      r_state, w_state_next;
  op_e         r_op, w_op_next;
  logic [31:0] r_cnt, w_cnt_next;
  logic [31:0] r_wait_cyc, w_wait_cyc_next;
  logic [7:0]  r_byte, w_byte_next;
  logic        r_rs, w_rs_next;
  logic        r_hi, w_hi_next;           // currently presenting the high nibble
  logic        r_nib_only, w_nib_only_next; // wakeup steps send the high nibble only
  logic [2:0]  r_init_idx, w_init_idx_next;
  logic        r_init_done, w_init_done_next;
  logic [7:0]  r_char, w_char_next;
  logic [1:0]  r_tgt_line, w_tgt_line_next;
  logic [5:0]  r_tgt_col, w_tgt_col_next;
  logic [1:0]  r_cur_line, w_cur_line_next;
  logic [5:0]  r_cur_col, w_cur_col_next;

  logic [1:0]  w_line_clamp;
  logic [5:0]  w_col_clamp;
  logic [6:0]  w_base;
  logic [6:0]  w_addr;
  logic [5:0]  w_col_inc;

  assign w_line_clamp = (i_pos_line > LastLine) ? LastLine : i_pos_line;
  assign w_col_clamp  = (i_pos_col > LastCol) ? LastCol : i_pos_col;
  assign w_col_inc    = r_cur_col + 6'd1;
  assign w_addr       = w_base + {1'b0, r_tgt_col};

`ifdef LCD_AUTO_WRAP_EN
  logic [1:0] w_line_inc;
  assign w_line_inc = (r_cur_line == LastLine) ? 2'd0 : r_cur_line + 2'd1;
`endif

  always_comb begin
    w_base = 7'h00;
    unique case (r_tgt_line)
      2'd0: w_base = 7'h00;
      2'd1: w_base = 7'h40;
      2'd2: w_base = Base2;
      2'd3: w_base = Base3;
      default: w_base = 7'h00;
    endcase
  end

  assign o_db          = r_hi ? r_byte[7:4] : r_byte[3:0];
  assign o_rs          = r_rs;
  assign o_enable      = (r_state == StEnHi);
  assign o_ready       = (r_state == StReady);
  assign o_cursor_line = r_cur_line;
  assign o_cursor_col  = r_cur_col;

  always_comb begin
    w_state_next     = r_state;
    w_op_next        = r_op;
    w_cnt_next       = r_cnt;
    w_wait_cyc_next  = r_wait_cyc;
    w_byte_next      = r_byte;
    w_rs_next        = r_rs;
    w_hi_next        = r_hi;
    w_nib_only_next  = r_nib_only;
    w_init_idx_next  = r_init_idx;
    w_init_done_next = r_init_done;
    w_char_next      = r_char;
    w_tgt_line_next  = r_tgt_line;
    w_tgt_col_next   = r_tgt_col;
    w_cur_line_next  = r_cur_line;
    w_cur_col_next   = r_cur_col;

    case (r_state)
      StPowerWait: begin
        if (r_cnt == PowerCyc - 1) begin
          w_cnt_next   = '0;
          w_state_next = StInitStep;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end

      StInitStep: begin
        w_hi_next       = 1'b1;
        w_rs_next       = 1'b0;
        w_nib_only_next = 1'b0;
        w_cnt_next      = '0;
        w_state_next    = StSetup;
        case (r_init_idx)
          3'd0, 3'd1, 3'd2: begin
            w_byte_next = 8'h30; w_nib_only_next = 1'b1; w_wait_cyc_next = WakeCyc;
          end
          3'd3: begin
            w_byte_next = 8'h20; w_nib_only_next = 1'b1; w_wait_cyc_next = ExecCyc;
          end
          3'd4:    begin w_byte_next = FuncSet; w_wait_cyc_next = ExecCyc;  end
          3'd5:    begin w_byte_next = 8'h0C;   w_wait_cyc_next = ExecCyc;  end
          3'd6:    begin w_byte_next = 8'h01;   w_wait_cyc_next = ClearCyc; end
          default: begin w_byte_next = 8'h06;   w_wait_cyc_next = ExecCyc;  end
        endcase
      end

      // One cycle between accept and the bus: builds the byte from latched operands.
      StLoad: begin
        w_hi_next       = 1'b1;
        w_nib_only_next = 1'b0;
        w_cnt_next      = '0;
        w_rs_next       = 1'b0;
        w_wait_cyc_next = ExecCyc;
        w_state_next    = StSetup;
        unique case (r_op)
          OpChar: begin
            w_byte_next = r_char;
            w_rs_next   = 1'b1;
          end
          OpClear, OpHome: begin
            w_byte_next     = (r_op == OpClear) ? 8'h01 : 8'h02;
            w_wait_cyc_next = ClearCyc;
            w_cur_line_next = 2'd0;
            w_cur_col_next  = 6'd0;
          end
          default: begin
            w_byte_next     = {1'b1, w_addr};
            w_cur_line_next = r_tgt_line;
            w_cur_col_next  = r_tgt_col;
          end
        endcase
      end

      StSetup: begin
        w_cnt_next   = '0;
        w_state_next = StEnHi;
      end

      StEnHi: begin
        if (r_cnt == EnCyc - 1) begin
          w_cnt_next   = '0;
          w_state_next = StEnLo;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end

      StEnLo: begin
        if (r_cnt == EnCyc - 1) begin
          w_cnt_next = '0;
          if (r_hi && !r_nib_only) begin
            w_hi_next    = 1'b0;
            w_state_next = StSetup;
          end else begin
            w_state_next = StWait;
          end
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end

      StWait: begin
        if (r_cnt == r_wait_cyc - 32'd1) begin
          w_cnt_next = '0;
          if (!r_init_done) begin
            if (r_init_idx == 3'd7) begin
              w_init_done_next = 1'b1;
              w_state_next     = StReady;
            end else begin
              w_init_idx_next = r_init_idx + 3'd1;
              w_state_next    = StInitStep;
            end
          end else if (r_op == OpChar) begin
`ifdef LCD_AUTO_WRAP_EN
            if (w_col_inc >= ColsW) begin
              // Move to the next line and re-address the LCD before going idle.
              w_cur_line_next = w_line_inc;
              w_cur_col_next  = 6'd0;
              w_tgt_line_next = w_line_inc;
              w_tgt_col_next  = 6'd0;
              w_op_next       = OpPos;
              w_state_next    = StLoad;
            end else begin
              w_cur_col_next = w_col_inc;
              w_state_next   = StReady;
            end
`else
            if (r_cur_col < ColsW) w_cur_col_next = w_col_inc;
            w_state_next = StReady;
`endif
          end else begin
            w_state_next = StReady;
          end
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end

      StReady: begin
        if (i_clear) begin
          w_op_next    = OpClear;
          w_state_next = StLoad;
        end else if (i_home) begin
          w_op_next    = OpHome;
          w_state_next = StLoad;
        end else if (i_set_pos) begin
          w_op_next       = OpPos;
          w_tgt_line_next = w_line_clamp;
          w_tgt_col_next  = w_col_clamp;
          w_state_next    = StLoad;
        end else if (i_write_char) begin
          w_op_next    = OpChar;
          w_char_next  = i_char;
          w_state_next = StLoad;
        end
      end

      default: w_state_next = StPowerWait;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StPowerWait;
      r_op        <= OpChar;
      r_cnt       <= '0;
      r_wait_cyc  <= '0;
      r_byte      <= '0;
      r_rs        <= 1'b0;
      r_hi        <= 1'b0;
      r_nib_only  <= 1'b0;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
      r_char      <= '0;
      r_tgt_line  <= '0;
      r_tgt_col   <= '0;
      r_cur_line  <= '0;
      r_cur_col   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_op        <= w_op_next;
      r_cnt       <= w_cnt_next;
      r_wait_cyc  <= w_wait_cyc_next;
      r_byte      <= w_byte_next;
      r_rs        <= w_rs_next;
      r_hi        <= w_hi_next;
      r_nib_only  <= w_nib_only_next;
      r_init_idx  <= w_init_idx_next;
      r_init_done <= w_init_done_next;
      r_char      <= w_char_next;
      r_tgt_line  <= w_tgt_line_next;
      r_tgt_col   <= w_tgt_col_next;
      r_cur_line  <= w_cur_line_next;
      r_cur_col   <= w_cur_col_next;
    end
  end

endmodule

// File: tb/tb_lcd_char_controller.sv
// Self-checking bench for lcd_char_controller with small delay parameters.
// Directed command vectors from a table, plus hand sequences for ignored
// strobes, line wrap / column saturation and reset during an enable pulse.
module tb_lcd_char_controller;

  localparam int EnCyc     = 2;
  localparam int PowerCyc  = 1000;
  localparam int ExecBusy  = 1 + 2 * 5 + 4;
  localparam int ClearBusy = 1 + 2 * 5 + 1000;

  logic       clk, rst;
  logic [7:0] ch;
  logic       wr, hm, clr, sp;
  logic [1:0] pl;
  logic [5:0] pc;
  logic [3:0] db;
  logic       rs, en, rdy;
  logic [1:0] cl;
  logic [5:0] cc;

  int n_cmp = 0;
  int n_fail = 0;
  int stable_err = 0;
  logic [4:0] q_nib [$];
  logic [3:0] init_nib [12];

  lcd_char_controller #(
    .CLK_MHZ(1), .POWER_MS(1), .WAKE_MS(1), .EN_US(2), .EXEC_US(4), .CLEAR_MS(1),
    .LINES(2), .COLS(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_char(ch), .i_write_char(wr), .i_home(hm),
    .i_clear(clr), .i_set_pos(sp), .i_pos_line(pl), .i_pos_col(pc),
    .o_db(db), .o_rs(rs), .o_enable(en), .o_ready(rdy),
    .o_cursor_line(cl), .o_cursor_col(cc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Captures every nibble latched by the LCD (rising enable) as {rs, db}.
  initial begin : mon
    logic       prev_en;
    int         hi_len;
    logic [4:0] cur, last;
    prev_en = 1'b0; hi_len = 0; cur = '0; last = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0;
        hi_len  = 0;
      end else begin
        if (en) begin
          if (!prev_en) begin
            cur = {rs, db};
            q_nib.push_back(cur);
            hi_len = 1;
            if (last !== cur) stable_err++;  // data must be set up a cycle early
          end else begin
            hi_len++;
            if ({rs, db} !== cur) stable_err++;
          end
        end else if (prev_en) begin
          check("enable_high_cycles", hi_len, EnCyc);
          if ({rs, db} !== cur) stable_err++;
        end
        prev_en = en;
      end
      last = {rs, db};
    end
  end

  function automatic logic [8:0] byte_of(input int k);
    logic [8:0] r;
    r = 'x;
    if (q_nib.size() >= 2 * k + 2 && q_nib[2*k][4] == q_nib[2*k+1][4])
      r = {q_nib[2*k][4], q_nib[2*k][3:0], q_nib[2*k+1][3:0]};
    return r;
  endfunction

  task automatic wait_ready(input string tag, input int limit, output int cyc);
    cyc = 0;
    while (rdy !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, rdy, 1);
  endtask

  task automatic check_init(input string tag);
    int cyc;
    wait_ready({tag, "_ready"}, 20000, cyc);
    check({tag, "_nibble_count"}, q_nib.size(), 12);
    for (int i = 0; i < 12; i++) begin
      logic [4:0] got;
      got = (i < q_nib.size()) ? q_nib[i] : 5'bx;
      check($sformatf("%s_nibble%0d", tag, i), got, {1'b0, init_nib[i]});
    end
  endtask

  task automatic do_op(input logic c, input logic h, input logic s, input logic w,
                       input logic [7:0] chr, input logic [1:0] ln, input logic [5:0] co,
                       output int busy);
    @(negedge clk);
    q_nib.delete();
    clr = c; hm = h; sp = s; wr = w; ch = chr; pl = ln; pc = co;
    @(negedge clk);
    // Scramble operands after the accept edge; only the accepted values may be used.
    clr = 1'b0; hm = 1'b0; sp = 1'b0; wr = 1'b0; ch = 8'hFF; pl = 2'd0; pc = 6'd0;
    busy = 0;
    while (rdy !== 1'b1 && busy < 5000) begin
      busy++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic       c, h, s, w;
    logic [7:0] chr;
    logic [1:0] ln;
    logic [5:0] co;
    logic [7:0] eb;
    logic       ers;
    logic [1:0] eln;
    logic [5:0] eco;
    int         ebusy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int busy, cyc;

    init_nib = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    //            clr   home  setp  wr    char   line  col    byte   rs    eline ecol   busy
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 2'd0, 6'd0,  8'h41, 1'b1, 2'd0, 6'd1,  ExecBusy};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd3, 6'd50, 8'hCF, 1'b0, 2'd1, 6'd15, ExecBusy};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 2'd0, 6'd0,  8'h01, 1'b0, 2'd0, 6'd0,  ClearBusy};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1, 6'd5,  8'hC5, 1'b0, 2'd1, 6'd5,  ExecBusy};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1, 6'd7,  8'h02, 1'b0, 2'd0, 6'd0,  ClearBusy};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 2'd0, 6'd3,  8'h83, 1'b0, 2'd0, 6'd3,  ExecBusy};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h7A, 2'd0, 6'd0,  8'h7A, 1'b1, 2'd0, 6'd4,  ExecBusy};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2, 6'd0,  8'hC0, 1'b0, 2'd1, 6'd0,  ExecBusy};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 6'd15, 8'h8F, 1'b0, 2'd0, 6'd15, ExecBusy};

    rst = 1'b1; ch = '0; wr = 1'b0; hm = 1'b0; clr = 1'b0; sp = 1'b0; pl = '0; pc = '0;
    repeat (3) @(negedge clk);
    check("reset_enable", en, 0);
    check("reset_rs", rs, 0);
    check("reset_db", db, 0);
    check("reset_ready", rdy, 0);
    check("reset_line", cl, 0);
    check("reset_col", cc, 0);

    @(posedge clk); #1 rst = 1'b0;
    check_init("init");
    check("init_cursor_line", cl, 0);
    check("init_cursor_col", cc, 0);

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].c, vecs[i].h, vecs[i].s, vecs[i].w, vecs[i].chr, vecs[i].ln, vecs[i].co,
            busy);
      check($sformatf("v%0d_busy", i), busy, vecs[i].ebusy);
      check($sformatf("v%0d_nibbles", i), q_nib.size(), 2);
      check($sformatf("v%0d_byte", i), byte_of(0), {vecs[i].ers, vecs[i].eb});
      check($sformatf("v%0d_line", i), cl, vecs[i].eln);
      check($sformatf("v%0d_col", i), cc, vecs[i].eco);
    end

    // Strobes while busy are dropped, not queued.
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 6'd2, busy);
    @(negedge clk);
    q_nib.delete();
    wr = 1'b1; ch = 8'h42;
    @(negedge clk);
    wr = 1'b0; ch = 8'hFF;
    repeat (3) @(negedge clk);
    clr = 1'b1; wr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0; wr = 1'b0;
    wait_ready("ign_ready", 5000, cyc);
    repeat (20) @(negedge clk);
    check("ign_still_ready", rdy, 1);
    check("ign_nibbles", q_nib.size(), 2);
    check("ign_byte", byte_of(0), {1'b1, 8'h42});
    check("ign_line", cl, 0);
    check("ign_col", cc, 3);

    // Fill line 0 and write past the last column.
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 6'd0, busy);
    for (int k = 0; k < 15; k++) begin
      do_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h30 + 8'(k), 2'd0, 6'd0, busy);
      check($sformatf("fill%0d_col", k), cc, k + 1);
    end
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 2'd0, 6'd0, busy);
    check("w16_byte", byte_of(0), {1'b1, 8'h5A});
`ifdef LCD_AUTO_WRAP_EN
    check("w16_busy", busy, 2 * ExecBusy);
    check("w16_nibbles", q_nib.size(), 4);
    check("w16_wrap_byte", byte_of(1), {1'b0, 8'hC0});
    check("w16_line", cl, 1);
    check("w16_col", cc, 0);
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h5B, 2'd0, 6'd0, busy);
    check("w17_line", cl, 1);
    check("w17_col", cc, 1);
`else
    check("w16_busy", busy, ExecBusy);
    check("w16_nibbles", q_nib.size(), 2);
    check("w16_line", cl, 0);
    check("w16_col", cc, 16);
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h5B, 2'd0, 6'd0, busy);
    check("w17_nibbles", q_nib.size(), 2);
    check("w17_line", cl, 0);
    check("w17_col", cc, 16);
`endif

    // Reset in the middle of an enable pulse restarts from the power-on wait.
    @(negedge clk);
    wr = 1'b1; ch = 8'h33;
    @(negedge clk);
    wr = 1'b0;
    cyc = 0;
    while (en !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_saw_enable", en, 1);
    @(posedge clk); #1 rst = 1'b1;
    check("rst_enable_when_asserted", en, 1);
    @(posedge clk); #1;
    check("rst_enable_after", en, 0);
    check("rst_rs_after", rs, 0);
    check("rst_db_after", db, 0);
    check("rst_ready_after", rdy, 0);
    check("rst_line_after", cl, 0);
    check("rst_col_after", cc, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q_nib.delete();
    cyc = 0;
    while (en !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_power_wait", (cyc >= PowerCyc) ? 32'd1 : 32'd0, 1);
    check_init("reinit");

    check("db_rs_stable", stable_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_char_controller.md
LCD_CHAR_CONTROLLER -- requirements
Module: lcd_char_controller

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 50, clock frequency in MHz; all delay cycle counts = CLK_MHZ x time.
REQ-002 SHALL have parameter POWER_MS, default 130, power-on wait.
REQ-003 SHALL have parameter WAKE_MS, default 10, wait after each wakeup nibble.
REQ-004 SHALL have parameter EN_US, default 1, enable high time and enable low hold time per nibble.
REQ-005 SHALL have parameter EXEC_US, default 50, wait after each full byte.
REQ-006 SHALL have parameter CLEAR_MS, default 2, wait after clear/home bytes (0x01, 0x02).
REQ-007 SHALL have parameter LINES, default 2, legal values 1, 2, 4.
REQ-008 SHALL have parameter COLS, default 16, legal range 8..40.
REQ-009 SHALL have port clk input 1: sole clock, rising edge.
REQ-010 SHALL have port rst input 1: synchronous, active-high reset.
REQ-011 SHALL have ports char input 8 (character code), write_char input 1, home input 1, clear input 1, set_pos input 1 (command strobes).
REQ-012 SHALL have ports pos_line input 2 and pos_col input 6: target for set_pos.
REQ-013 SHALL have ports db output 4 (LCD DB7..DB4, db[0]=DB4), rs output 1, enable output 1.
REQ-014 SHALL have port ready output 1: high = idle, able to accept one strobe.
REQ-015 SHALL have ports cursor_line output 2 and cursor_col output 6: tracked cursor position.

Function
REQ-016 SHALL run init states: POWER_WAIT, then three WAKE nibbles 0x3 (rs=0), each followed by WAKE_MS, then nibble 0x2, then bytes 0x28 (0x20 when LINES=1), 0x0C, 0x01 (CLEAR_MS wait), 0x06, then enter READY.
REQ-017 SHALL send each nibble as: drive db/rs for 1 cycle with enable=0; enable=1 for EN cycles; enable=0 for EN cycles; db/rs held stable throughout.
REQ-018 SHALL send bytes high nibble first, then low nibble, then EXEC_US wait (CLEAR_MS for 0x01/0x02).
REQ-019 SHALL accept a strobe only in READY with ready=1; ready SHALL be 0 from the next cycle until the operation's final wait ends; strobes while ready=0 are ignored, not queued.
REQ-020 SHALL resolve simultaneous strobes by priority clear > home > set_pos > write_char; lower strobes are dropped.
REQ-021 SHALL, on write_char, send char with rs=1, then increment cursor_col.
REQ-022 SHALL, on clear, send 0x01 (rs=0); on home, send 0x02 (rs=0); both set cursor to (0,0).
REQ-023 SHALL, on set_pos, clamp line to LINES-1 and col to COLS-1, send 0x80|addr (rs=0), and update the cursor to the clamped values.
REQ-024 SHALL compute addr = base[line] + col, with base = {0x00, 0x40, COLS, 0x40+COLS}.
REQ-025 SHALL sample char/pos inputs only on the accepting cycle.

Reset
REQ-026 SHALL, on rst, drive next cycle: enable=0, rs=0, db=0, ready=0, cursor=(0,0), all counters 0, state POWER_WAIT.
REQ-027 SHALL, when rst is asserted mid-nibble or mid-init, abort the operation and restart the full sequence including POWER_WAIT.

Configuration
REQ-028 SHALL, with LCD_AUTO_WRAP_EN defined, on a write that leaves cursor_col=COLS: set col=0, line=(line+1) mod LINES, and send 0x80|addr of the new position before raising ready.
REQ-029 SHALL, without LCD_AUTO_WRAP_EN, saturate cursor_col at COLS, send no extra command, and leave cursor_line unchanged.

Verification (CLK_MHZ=1, POWER_MS=1, WAKE_MS=1, EN_US=2, EXEC_US=4, CLEAR_MS=1, LINES=2, COLS=16)
REQ-030 SHALL cover: release rst -> nibble sequence 3,3,3,2,2,8,0,C,0,1,0,6 on db, rs=0, each enable high exactly 2 cycles; ready rises after the last wait.
REQ-031 SHALL cover: write_char char=0x41 in READY -> rs=1, nibbles 4 then 1; cursor (0,1); ready=0 for 1+2x5+4 cycles.
REQ-032 SHALL cover: set_pos line=3 col=50 -> clamped (1,15), byte 0xCF sent.
REQ-033 SHALL cover: clear and write_char strobed in the same cycle -> only 0x01 sent; cursor (0,0); write dropped.
REQ-034 SHALL cover: with LCD_AUTO_WRAP_EN, 16 writes from (0,0) -> 17th byte is 0xC0, cursor (1,0); without the macro -> no 0xC0, cursor_col=16.
REQ-035 SHALL cover: rst asserted while enable=1 -> enable=0 next cycle, init restarts from POWER_WAIT.
